// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, sequencer
// states and the R-type funct codes decode uses to steer HI/LO traffic.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PREP  = 2'b01,
        CALC  = 2'b10,
        FIXUP = 2'b11
    } mdu_state_e;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return !op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// shift-subtract for divide. acc holds {upper, lower} halves.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  mdu_op_e            mode,
    output logic [2*WIDTH-1:0] acc_nx
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   top;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: conditionally add the multiplicand, then shift the carry in from the top.
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: the partial remainder shifted left with the next dividend bit.
        top  = acc[2*WIDTH-1:WIDTH-1];
        ge   = (top >= {1'b0, operand});
        diff = top[WIDTH-1:0] - operand;
        if (op_is_div(mode)) begin
            if (ge) acc_nx = {diff, acc[WIDTH-2:0], 1'b1};
            else    acc_nx = {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nx = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. Signed ops run on
// magnitudes and are sign-corrected in FIXUP; busy stalls the pipeline.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state, state_nx;
    logic [CNT_W-1:0]   cnt;
    mdu_op_e            op_r;
    logic [WIDTH-1:0]   a_raw, b_raw, divisor;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic               neg_q, neg_r, zero_div;

    logic               is_div, is_signed, last_step;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_div    = op_is_div(op_r);
    assign is_signed = op_is_signed(op_r);
    assign last_step = (cnt == CNT_W'(WIDTH-1));
    assign a_mag     = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
    assign b_mag     = (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
    assign prod_fix  = neg_q ? -acc : acc;
    assign quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .operand (divisor),
        .mode    (op_r),
        .acc_nx  (acc_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid && !cancel) state_nx = PREP;
            PREP:    state_nx = cancel ? IDLE : CALC;
            CALC:    if (cancel) state_nx = IDLE;
                     else if (last_step) state_nx = FIXUP;
            FIXUP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            op_r     <= MDU_MULT;
            a_raw    <= '0;
            b_raw    <= '0;
            divisor  <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    // Latched every idle cycle; only the accepting edge matters.
                    op_r  <= mdu_op_e'(req_op);
                    a_raw <= op_a;
                    b_raw <= op_b;
                end
                PREP: begin
                    acc      <= {{WIDTH{1'b0}}, a_mag};
                    divisor  <= b_mag;
                    neg_q    <= is_signed && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                    neg_r    <= is_signed && a_raw[WIDTH-1];
                    zero_div <= is_div && (b_raw == '0);
                    cnt      <= '0;
                end
                CALC: begin
                    acc <= acc_nx;
                    cnt <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    if (!cancel) begin
                        done     <= 1'b1;
                        div_zero <= zero_div;
                        if (zero_div) begin
                            lo <= '1;
                            hi <= a_raw;
                        end else if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO register pair and sits in EX beside the single-cycle ALU. Decode drives it for the R-type functs mult/multu/div/divu (0x18-0x1b) and for mthi/mtlo (0x11/0x13). It reads HI/LO combinationally for mfhi/mflo (0x10/0x12). `busy` is the pipeline stall source while an operation is iterating.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  start request; sampled only in IDLE
req_op  in  2  00 mult, 01 multu, 10 div, 11 divu
op_a  in  WIDTH  rs value (multiplicand / dividend)
op_b  in  WIDTH  rt value (multiplier / divisor)
wr_hi  in  1  mthi strobe
wr_lo  in  1  mtlo strobe
wr_data  in  WIDTH  mthi/mtlo data
cancel  in  1  pipeline flush; aborts an in-flight op
busy  out  1  high while not IDLE; stall request
done  out  1  one-cycle pulse when the result is written to HI/LO
div_zero  out  1  one-cycle pulse, coincident with done, for div/divu with op_b==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, counter=0, hi=lo=0, busy=done=div_zero=0. Reset takes priority over everything, including mid-operation.
- States:
  - IDLE -> PREP on req_valid && !cancel. Operands and op are latched at that edge.
  - PREP: for signed ops, take absolute values and record the result sign (quotient/product sign = sign_a^sign_b; remainder sign = sign_a). For unsigned ops, pass the operands through. -> CALC, counter=0.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle. counter increments; after the step with counter==WIDTH-1 -> FIXUP.
  - FIXUP: apply two's-complement sign correction, write HI/LO, assert done (and div_zero if applicable) registered for the next cycle. -> IDLE.
- Latency: the acceptance edge is E0. hi, lo, done and div_zero update at edge E0+WIDTH+2, which is 34 cycles for WIDTH=32. busy=1 from E0 until E0+WIDTH+2; busy is 0 in the cycle done is high.
- Results:
  - mult/multu: {hi,lo} = 2*WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder. The remainder carries the dividend's sign; the quotient truncates toward zero.
  - Divide by zero: lo = all ones, hi = op_a (unmodified); div_zero pulses.
  - Signed overflow (min_int / -1): lo = min_int, hi = 0, with no special flag.
- mthi/mtlo:
  - When in IDLE, wr_hi/wr_lo update hi/lo at the next edge. Both may be asserted together.
  - While busy, they are ignored; decode must stall on busy.
  - If wr_* and req_valid occur in the same IDLE cycle, the write takes effect and the later result overwrites it.
- req_valid while busy is ignored; there is no queueing.
- cancel:
  - In PREP/CALC/FIXUP, the next state is IDLE. No done pulse, and hi/lo keep their pre-op values.
  - cancel in FIXUP beats the write.
  - cancel with req_valid in IDLE means the request is not accepted.
- done and div_zero are 0 in every cycle except the single completion cycle.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU;
  - state enum IDLE/PREP/CALC/FIXUP;
  - funct constants 0x10-0x13 and 0x18-0x1b used by decode.
- One sub-module mdu_step: combinational single-iteration datapath, taking {acc, operand, mode} and producing the next acc. mdu_ctrl keeps the FSM, counter, sign bookkeeping and HI/LO registers.

Test Plan:
- multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the acceptance edge; busy high for 34 cycles.
- mult -3 (0xFFFFFFFD) * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 0x64/0 -> lo=0xFFFFFFFF, hi=0x00000064, div_zero and done pulse together for one cycle. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via wr_hi/wr_lo; start div; cancel at cycle 10 -> busy drops next edge, no done, hi=0x11, lo=0x22. An immediately following multu 6*7 yields lo=42, hi=0.
- wr_hi=1 with wr_data=0xDEAD during CALC -> hi unchanged. req_valid during CALC -> no second op. req_valid+cancel in IDLE -> busy stays 0.
- reset low mid-CALC -> next cycle busy=0, hi=lo=0, done=0. Operation after reset release completes normally.
